// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder -- RV32I decode stage between fetch and execute.
//
// Accepts a fetched word and its PC over a valid/ready handshake. Decodes the
// word combinationally and captures the result in an output register. A
// one-entry skid buffer keeps the stage at full throughput when execute
// applies backpressure.
//
// Ports
//   clk            clock
//   reset          asynchronous active-low reset
//   fetcher_valid  upstream word valid
//   decoder_ready  stage can accept a word this cycle (no skid entry held)
//   instr          fetched instruction word
//   fetcher_pc     PC of instr
//   flush          drop all held and incoming work
//   executor_ready downstream accepts the outputs this cycle
//   decoder_valid  decoded outputs valid
//   decoder_pc     PC of the decoded instruction
//   op             operation class (15 = illegal)
//   funct3         instr[14:12]
//   alt            instr[30] for OP, and for OP_IMM shifts; else 0
//   rd/rs1/rs2     register indices, forced to 0 where the format lacks them
//   imm            sign-extended immediate
//   illegal        1 iff op == 15
// ---------------------------------------------------------------------------
module decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetcher_valid,
  output logic        decoder_ready,
  input  logic [31:0] instr,
  input  logic [31:0] fetcher_pc,
  input  logic        flush,
  input  logic        executor_ready,
  output logic        decoder_valid,
  output logic [31:0] decoder_pc,
  output logic [3:0]  op,
  output logic [2:0]  funct3,
  output logic        alt,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        illegal
);

  typedef enum logic [3:0] {
    OP_LUI     = 4'd0,
    OP_AUIPC   = 4'd1,
    OP_JAL     = 4'd2,
    OP_JALR    = 4'd3,
    OP_BRANCH  = 4'd4,
    OP_LOAD    = 4'd5,
    OP_STORE   = 4'd6,
    OP_OPIMM   = 4'd7,
    OP_OP      = 4'd8,
    OP_FENCE   = 4'd9,
    OP_SYSTEM  = 4'd10,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef struct packed {
    logic [31:0] pc;
    op_e         op;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  localparam dec_t DEC_ZERO = '{
    pc: 32'd0, op: OP_LUI, funct3: 3'd0, alt: 1'b0, rd: 5'd0,
    rs1: 5'd0, rs2: 5'd0, imm: 32'd0, illegal: 1'b0
  };

  // Immediate candidates for each format.
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [6:0]  funct7_s;
  logic [2:0]  f3_s;
  logic        legal_s;
  dec_t        dec_s;

  dec_t        out_q, out_d;
  dec_t        skid_q, skid_d;
  logic        valid_q, valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        accept_s, drain_s;

  assign funct7_s = instr[31:25];
  assign f3_s     = instr[14:12];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s  = {instr[31:12], 12'd0};
  assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Combinational decode of the incoming word.
  always_comb begin
    dec_s         = DEC_ZERO;
    dec_s.pc      = fetcher_pc;
    dec_s.funct3  = f3_s;
    dec_s.rd      = instr[11:7];
    dec_s.rs1     = instr[19:15];
    dec_s.rs2     = instr[24:20];
    legal_s       = 1'b1;
    // The low two opcode bits are part of every listed opcode, so a word
    // with instr[1:0] != 11 falls into the default arm.
    case (instr[6:0])
      7'b0110111: begin
        dec_s.op = OP_LUI;   dec_s.imm = imm_u_s;
        dec_s.rs1 = 5'd0;    dec_s.rs2 = 5'd0;
      end
      7'b0010111: begin
        dec_s.op = OP_AUIPC; dec_s.imm = imm_u_s;
        dec_s.rs1 = 5'd0;    dec_s.rs2 = 5'd0;
      end
      7'b1101111: begin
        dec_s.op = OP_JAL;   dec_s.imm = imm_j_s;
        dec_s.rs1 = 5'd0;    dec_s.rs2 = 5'd0;
      end
      7'b1100111: begin
        dec_s.op = OP_JALR;  dec_s.imm = imm_i_s; dec_s.rs2 = 5'd0;
        legal_s  = (f3_s == 3'b000);
      end
      7'b1100011: begin
        dec_s.op = OP_BRANCH; dec_s.imm = imm_b_s; dec_s.rd = 5'd0;
        legal_s  = (f3_s != 3'b010) && (f3_s != 3'b011);
      end
      7'b0000011: begin
        dec_s.op = OP_LOAD;  dec_s.imm = imm_i_s; dec_s.rs2 = 5'd0;
        legal_s  = (f3_s != 3'b011) && (f3_s != 3'b110) && (f3_s != 3'b111);
      end
      7'b0100011: begin
        dec_s.op = OP_STORE; dec_s.imm = imm_s_s; dec_s.rd = 5'd0;
        legal_s  = (f3_s <= 3'b010);
      end
      7'b0010011: begin
        dec_s.op = OP_OPIMM; dec_s.imm = imm_i_s; dec_s.rs2 = 5'd0;
        if (f3_s == 3'b001) begin
          legal_s = (funct7_s == 7'b0000000);
        end else if (f3_s == 3'b101) begin
          legal_s   = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
          dec_s.alt = instr[30];
        end else begin
          legal_s = 1'b1;
        end
      end
      7'b0110011: begin
        dec_s.op  = OP_OP;   dec_s.imm = 32'd0;
        dec_s.alt = instr[30];
        legal_s   = (funct7_s == 7'b0000000) ||
                    ((funct7_s == 7'b0100000) && ((f3_s == 3'b000) || (f3_s == 3'b101)));
      end
      7'b0001111: begin
        dec_s.op = OP_FENCE;  dec_s.imm = imm_i_s; dec_s.rs2 = 5'd0;
      end
      7'b1110011: begin
        dec_s.op = OP_SYSTEM; dec_s.imm = imm_i_s; dec_s.rs2 = 5'd0;
      end
      default: begin
        legal_s = 1'b0;
      end
    endcase
    // Illegal words carry only pc and funct3; everything else is zeroed.
    if (!legal_s) begin
      dec_s.op      = OP_ILLEGAL;
      dec_s.rd      = 5'd0;
      dec_s.rs1     = 5'd0;
      dec_s.rs2     = 5'd0;
      dec_s.imm     = 32'd0;
      dec_s.alt     = 1'b0;
      dec_s.illegal = 1'b1;
    end else begin
      dec_s.illegal = 1'b0;
    end
  end

  assign accept_s = fetcher_valid && !skid_valid_q;
  assign drain_s  = valid_q && executor_ready;

  // Output register / skid routing; flush overrides every other event.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    valid_d      = valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!valid_q || drain_s) begin
      // Output slot frees up: the older skid entry goes first. accept_s is
      // necessarily 0 while the skid is occupied.
      if (skid_valid_q) begin
        out_d        = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_d   = dec_s;
        valid_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end else begin
      // Output held by backpressure: a new word parks in the skid.
      if (accept_s) begin
        skid_d       = dec_s;
        skid_valid_d = 1'b1;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q        <= DEC_ZERO;
      skid_q       <= DEC_ZERO;
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      valid_q      <= valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign decoder_ready = !skid_valid_q;
  assign decoder_valid = valid_q;
  assign decoder_pc    = out_q.pc;
  assign op            = out_q.op;
  assign funct3        = out_q.funct3;
  assign alt           = out_q.alt;
  assign rd            = out_q.rd;
  assign rs1           = out_q.rs1;
  assign rs2           = out_q.rs2;
  assign imm           = out_q.imm;
  assign illegal       = out_q.illegal;

endmodule

// File: tb/tb_decoder.sv
// ---------------------------------------------------------------------------
// tb_decoder -- self-checking bench for the RV32I decode stage.
// The stage is modelled as an in-order queue holding at most two decoded
// entries; each entry is produced by an instruction-set-level reference
// decoder.
// ---------------------------------------------------------------------------
module tb_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetcher_valid;
  logic        decoder_ready;
  logic [31:0] instr;
  logic [31:0] fetcher_pc;
  logic        flush;
  logic        executor_ready;
  logic        decoder_valid;
  logic [31:0] decoder_pc;
  logic [3:0]  op;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        illegal;

  decoder dut (
    .clk(clk), .reset(reset), .fetcher_valid(fetcher_valid),
    .decoder_ready(decoder_ready), .instr(instr), .fetcher_pc(fetcher_pc),
    .flush(flush), .executor_ready(executor_ready),
    .decoder_valid(decoder_valid), .decoder_pc(decoder_pc), .op(op),
    .funct3(funct3), .alt(alt), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          op;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal;
  } exp_t;

  // Opcode of each operation class; the class number is the table index.
  localparam logic [6:0] OPC [11] = '{
    7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011
  };

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   cls;
    logic ok;
    logic [2:0] f3;
    logic [6:0] f7;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    f3 = w[14:12];
    f7 = w[31:25];
    cls = -1;
    for (int k = 0; k < 11; k++) if (OPC[k] == w[6:0]) cls = k;
    e.pc = pc; e.funct3 = f3; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.alt = 1'b0; e.imm = 32'd0; e.op = cls;
    ok = (cls >= 0);
    case (cls)
      3: ok = (f3 == 3'd0);
      4: ok = !(f3 inside {3'd2, 3'd3});
      5: ok = !(f3 inside {3'd3, 3'd6, 3'd7});
      6: ok = (f3 <= 3'd2);
      7: if (f3 == 3'd1) ok = (f7 == 7'd0);
         else if (f3 == 3'd5) ok = (f7 inside {7'd0, 7'd32});
      8: ok = (f7 == 7'd0) || (f7 == 7'd32 && f3 inside {3'd0, 3'd5});
      default: ;
    endcase
    // Immediates from the bit-scatter of each format, sign-extended via int.
    if (cls inside {0, 1}) begin
      e.imm = w & 32'hFFFF_F000; e.rs1 = 5'd0; e.rs2 = 5'd0;
    end else if (cls == 2) begin
      j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      e.imm = int'(j21); e.rs1 = 5'd0; e.rs2 = 5'd0;
    end else if (cls inside {3, 5, 7, 9, 10}) begin
      i12 = w[31:20];
      e.imm = int'(i12); e.rs2 = 5'd0;
    end else if (cls == 6) begin
      i12 = {w[31:25], w[11:7]};
      e.imm = int'(i12); e.rd = 5'd0;
    end else if (cls == 4) begin
      b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      e.imm = int'(b13); e.rd = 5'd0;
    end
    if (cls == 8 || (cls == 7 && f3 == 3'd5)) e.alt = w[30];
    if (!ok) begin
      e.op = 15; e.rd = 5'd0; e.rs1 = 5'd0; e.rs2 = 5'd0; e.imm = 32'd0; e.alt = 1'b0;
    end
    e.illegal = !ok;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("decoder_valid", 32'(decoder_valid), 32'(q.size() > 0));
    check("decoder_ready", 32'(decoder_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      check("decoder_pc", decoder_pc, q[0].pc);
      check("op",         32'(op), 32'(q[0].op));
      check("funct3",     32'(funct3), 32'(q[0].funct3));
      check("alt",        32'(alt), 32'(q[0].alt));
      check("rd",         32'(rd), 32'(q[0].rd));
      check("rs1",        32'(rs1), 32'(q[0].rs1));
      check("rs2",        32'(rs2), 32'(q[0].rs2));
      check("imm",        imm, q[0].imm);
      check("illegal",    32'(illegal), 32'(q[0].illegal));
    end
  endtask

  // One clock: model the edge from the inputs as driven, then check.
  task automatic cycle();
    bit acc, drn;
    exp_t e;
    acc = fetcher_valid && (q.size() < 2);
    drn = (q.size() > 0) && executor_ready;
    e   = ref_decode(instr, fetcher_pc);
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    check_all();
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    fetcher_valid = 1'b1; instr = w; fetcher_pc = pc;
    cycle();
    fetcher_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b0; fetcher_valid = 1'b0; instr = 32'd0; fetcher_pc = 32'd0;
    flush = 1'b0; executor_ready = 1'b1;
    #12;
    check("rst_valid", 32'(decoder_valid), 32'd0);
    check("rst_ready", 32'(decoder_ready), 32'd1);
    check("rst_imm",   imm, 32'd0);
    check("rst_pc",    decoder_pc, 32'd0);
    reset = 1'b1;
    cycle();

    // addi x1, x0, 5
    send(32'h0050_0093, 32'h0000_0000);
    check("addi_op", 32'(op), 32'd7);
    check("addi_rd", 32'(rd), 32'd1);
    check("addi_imm", imm, 32'd5);

    // beq x0, x0, -4 at 0x100
    send(32'hFE00_0EE3, 32'h0000_0100);
    check("beq_op", 32'(op), 32'd4);
    check("beq_imm", imm, 32'hFFFF_FFFC);
    check("beq_pc", decoder_pc, 32'h0000_0100);

    // lui then sub back-to-back
    fetcher_valid = 1'b1; instr = 32'h1234_52B7; fetcher_pc = 32'h0000_0104;
    cycle();
    check("lui_imm", imm, 32'h1234_5000);
    instr = 32'h4020_81B3; fetcher_pc = 32'h0000_0108;
    cycle();
    check("sub_op", 32'(op), 32'd8);
    check("sub_alt", 32'(alt), 32'd1);
    fetcher_valid = 1'b0;

    // All-zero and all-one words are illegal, in order.
    fetcher_valid = 1'b1; instr = 32'h0000_0000; fetcher_pc = 32'h0000_0200;
    cycle();
    instr = 32'hFFFF_FFFF; fetcher_pc = 32'h0000_0204;
    cycle();
    check("ill_op", 32'(op), 32'd15);
    fetcher_valid = 1'b0;
    cycle();

    // Backpressure: A in output, B in skid, C refused.
    executor_ready = 1'b0;
    send(32'h0010_0113, 32'h0000_0300);
    send(32'h0020_0193, 32'h0000_0304);
    check("skid_ready", 32'(decoder_ready), 32'd0);
    fetcher_valid = 1'b1; instr = 32'h0030_0213; fetcher_pc = 32'h0000_0308;
    cycle();
    check("held_pc", decoder_pc, 32'h0000_0300);
    fetcher_valid = 1'b0; executor_ready = 1'b1;
    cycle();
    check("drain_b_pc", decoder_pc, 32'h0000_0304);
    cycle();

    // Flush with output and skid full and an incoming word.
    executor_ready = 1'b0;
    send(32'h0040_0293, 32'h0000_0400);
    send(32'h0050_0313, 32'h0000_0404);
    flush = 1'b1; fetcher_valid = 1'b1; instr = 32'h0060_0393;
    cycle();
    flush = 1'b0; fetcher_valid = 1'b0;
    check("flush_valid", 32'(decoder_valid), 32'd0);
    check("flush_ready", 32'(decoder_ready), 32'd1);
    executor_ready = 1'b1;
    cycle();

    // Asynchronous reset in the middle of a stall.
    executor_ready = 1'b0;
    send(32'h0070_0413, 32'h0000_0500);
    send(32'h0080_0493, 32'h0000_0504);
    #2 reset = 1'b0;
    #1;
    check("async_valid", 32'(decoder_valid), 32'd0);
    check("async_ready", 32'(decoder_ready), 32'd1);
    check("async_imm", imm, 32'd0);
    q.delete();
    @(negedge clk) reset = 1'b1;
    executor_ready = 1'b1;
    cycle();

    // Randomised traffic with backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        w[6:0] = OPC[$urandom_range(0, 10)];
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'd32 : 7'd0;
      end
      instr          = w;
      fetcher_pc     = $urandom;
      fetcher_valid  = ($urandom_range(0, 3) != 0);
      executor_ready = ($urandom_range(0, 2) != 0);
      flush          = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- RV32I instruction decode stage, directly downstream of the fetch stage.
- Consumes the fetched word and its PC over a valid/ready handshake. Produces decoded fields (operation class, register indices, sign-extended immediate, funct3/alt bit, illegal flag) over a second valid/ready handshake to the execute stage.
- Registered output plus a one-entry skid buffer, so full throughput is sustained while downstream backpressure is absorbed.

Parameters:
- none

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- fetcher_valid  input  1  upstream word valid
- decoder_ready  output  1  stage can accept a word this cycle
- instr  input  32  fetched instruction word
- fetcher_pc  input  32  PC of instr
- flush  input  1  discard all held and incoming work (branch/trap redirect)
- executor_ready  input  1  downstream accepts decoder outputs this cycle
- decoder_valid  output  1  decoded outputs valid
- decoder_pc  output  32  PC of decoded instruction
- op  output  4  class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL
- funct3  output  3  instr[14:12]
- alt  output  1  instr[30] for OP, and for OP_IMM with funct3=101; else 0
- rd  output  5  destination register
- rs1  output  5  source 1
- rs2  output  5  source 2
- imm  output  32  sign-extended immediate
- illegal  output  1  1 iff op==15

Behaviour:
- Reset (reset==0, asynchronous): decoder_valid=0, skid entry invalid, all data outputs 0. decoder_ready=1 (it equals !skid_valid).
- Accept when fetcher_valid && decoder_ready at the clock edge. Decode is combinational on instr and is captured into a register.
- Latency: an accepted word appears on the outputs with decoder_valid=1 the next cycle.
- Transfer out when decoder_valid && executor_ready.
- Routing of an accepted word:
  - Output register empty, or being drained this cycle, with skid empty: word goes to the output register.
  - Output register held (decoder_valid && !executor_ready): word goes to skid; decoder_ready=0 the next cycle.
  - Output drained while skid is valid: skid moves to the output; skid is cleared.
- Program order is always preserved.
- Outputs are stable while decoder_valid && !executor_ready.
- flush=1: decoder_valid=0 and skid cleared the next cycle. Any word accepted in the same cycle is discarded. Flush has priority over all other events.
- Formats, selected by instr[6:0]:
  - U (LUI 0110111, AUIPC 0010111): imm={instr[31:12],12'b0}; rs1=rs2=0.
  - J (JAL 1101111): imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],0}); rs1=rs2=0.
  - I (JALR 1100111, LOAD 0000011, OP_IMM 0010011, SYSTEM 1110011, FENCE 0001111): imm=sext(instr[31:20]); rs2=0.
  - S (0100011): imm=sext({instr[31:25],instr[11:7]}); rd=0.
  - B (1100011): imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); rd=0.
  - R (OP 0110011): imm=0.
- rd/rs1/rs2 take instr[11:7]/[19:15]/[24:20] unless forced 0 above.
- Illegal, which gives op=15 with rd=rs1=rs2=0 and imm=0:
  - instr[1:0]!=11, or unlisted opcode.
  - JALR funct3!=0.
  - BRANCH funct3 in {010,011}.
  - LOAD funct3 in {011,110,111}.
  - STORE funct3>010.
  - OP: funct7 not 0000000, or 0100000 with funct3 other than 000/101.
  - OP_IMM funct3=001 with funct7!=0.
  - OP_IMM funct3=101 with funct7 not in {0000000,0100000}.
- Illegal words still flow through the handshake; no stall or trap is raised here.
- Reset asserted mid-transfer: all held words are dropped immediately.

Test Plan:
- Send 0x00500093 with executor_ready=1 -> next cycle: decoder_valid=1, op=7, rd=1, rs1=0, imm=5, funct3=0, illegal=0.
- Send 0xFE000EE3 (beq x0,x0,-4), pc=0x100 -> op=4, rd=0, imm=0xFFFFFFFC, decoder_pc=0x100.
- Send 0x123452B7, then 0x402081B3 back-to-back:
  - first -> op=0, rd=5, imm=0x12345000;
  - second -> op=8, rd=3, rs1=1, rs2=2, alt=1.
- Send 0x00000000 and 0xFFFFFFFF -> op=15, illegal=1, decoder_valid=1 each, in order.
- Hold executor_ready=0 and send A, then B:
  - B lands in skid, decoder_ready=0, outputs stay equal to A;
  - raise executor_ready -> A, then B, on consecutive cycles, and decoder_ready returns to 1.
- With output and skid both full, pulse flush while fetcher_valid=1 -> next cycle decoder_valid=0 and decoder_ready=1; no word is ever transferred.
- Drive reset=0 asynchronously mid-stall -> decoder_valid=0 without a clock edge.
